// File: rtl/bmf_h_decoder.sv
// Boolean-matrix-factor decoder: each output column is an OR/XOR reduction of the
// masked factor word, behind a double-buffered (shadow/active) column configuration.
module bmf_h_decoder #(
    parameter int K  = 4,
    parameter int M  = 5,
    parameter int CW = 16,
    localparam int AW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [K-1:0]  cfg_mask,
    input  logic          cfg_xor,
    input  logic          cfg_commit,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_y,
    output logic [CW-1:0] xfer_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [K-1:0]  shadow_mask_q [M];
    logic [K-1:0]  shadow_mask_d [M];
    logic [K-1:0]  active_mask_q [M];
    logic [K-1:0]  active_mask_d [M];
    logic [M-1:0]  shadow_xor_q, shadow_xor_d;
    logic [M-1:0]  active_xor_q, active_xor_d;
    logic          out_valid_q, out_valid_d;
    logic [M-1:0]  out_y_q, out_y_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;
    logic          cfg_err_q, cfg_err_d;

    logic          in_fire;
    logic          out_fire;
    logic          do_copy;
    logic          addr_ok;
    logic [M-1:0]  decoded;

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign addr_ok   = int'(cfg_addr) < M;
    assign busy      = (state_q != S_RUN);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign cfg_err   = cfg_err_q;

    always_comb begin
        decoded = '0;
        for (int j = 0; j < M; j++) begin
            if (active_xor_q[j]) decoded[j] = ^(in_k & active_mask_q[j]);
            else                 decoded[j] = |(in_k & active_mask_q[j]);
        end
    end

    // DRAIN waits for the held word to leave, so the new config never touches it
    always_comb begin
        state_d = state_q;
        do_copy = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_commit) begin
                    do_copy = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_commit) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!out_valid_q || out_fire) begin
                    do_copy = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active_mask_d = active_mask_q;
        active_xor_d  = active_xor_q;
        shadow_mask_d = shadow_mask_q;
        shadow_xor_d  = shadow_xor_q;
        if (do_copy) begin
            active_mask_d = shadow_mask_q;
            active_xor_d  = shadow_xor_q;
        end
        for (int j = 0; j < M; j++) begin
            if (cfg_we && int'(cfg_addr) == j) begin
                shadow_mask_d[j] = cfg_mask;
                shadow_xor_d[j]  = cfg_xor;
            end
        end
        cfg_err_d = cfg_err_q | (cfg_we && !addr_ok);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_y_d     = decoded;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        xfer_cnt_d = xfer_cnt_q;
        if (out_fire && xfer_cnt_q != {CW{1'b1}}) xfer_cnt_d = xfer_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shadow_xor_q <= '0;
            active_xor_q <= '0;
            for (int j = 0; j < M; j++) begin
                shadow_mask_q[j] <= '0;
                active_mask_q[j] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            xfer_cnt_q   <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_mask_q <= shadow_mask_d;
            shadow_xor_q  <= shadow_xor_d;
            active_mask_q <= active_mask_d;
            active_xor_q  <= active_xor_d;
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            xfer_cnt_q    <= xfer_cnt_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

endmodule
